hd_tdm_demux4: RTL
==================

HD_TDM_DEMUX4 -- requirements
Module: hd_tdm_demux4

Interface
REQ-001 The block SHALL have parameter INVERT, default 1, meaning DIN carries inverted data (1 = complement each sampled bit, 0 = pass it unchanged).
REQ-002 The block SHALL have parameter MISS_LIMIT, default 2, meaning the number of consecutive missing SYNC marks (legal range 1..3) that drops lock.
REQ-003 The block SHALL have port CK, input, width 1: the single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port RN, input, width 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port DIN, input, width 1: serial data from a 4:1 inverting mux, one bit per slot.
REQ-006 The block SHALL have port SYNC, input, width 1: frame marker, high during slot 0.
REQ-007 The block SHALL have port EN, input, width 1: slot advance; when EN=0 all state holds.
REQ-008 The block SHALL have port SL, output, width 2: current slot index; this drives the far-end mux select lines SL1:SL0.
REQ-009 The block SHALL have port Q, output, width 4: the last complete frame, with Q[n] taken from slot n.
REQ-010 The block SHALL have port VLD, output, width 1: one-cycle pulse that marks a new Q.
REQ-011 The block SHALL have port ERR, output, width 1: one-cycle pulse on a misaligned SYNC or on loss of lock.
REQ-012 The block SHALL have port LOCKED, output, width 1: high while the state is LOCK.

Function
REQ-013 A sampled bit SHALL be b = DIN xor INVERT.
REQ-014 The block SHALL implement two states, HUNT and LOCK; nothing changes on any edge where EN=0.
REQ-015 In HUNT: SL=0; on EN and SYNC, the block SHALL store b in shadow[0], set SL to 1 and enter LOCK.
REQ-016 In HUNT, an EN edge without SYNC SHALL discard the bit.
REQ-017 In LOCK, each EN edge SHALL store b in shadow[SL] and increment SL modulo 4, so slot 3 wraps to 0.
REQ-018 On the EN edge that samples slot 3, Q SHALL be loaded with {b, shadow[2:0]} and VLD SHALL go high; VLD returns low on the next edge.
REQ-019 Latency SHALL be zero cycles from the slot-3 sample to Q and VLD.
REQ-020 In LOCK at SL=0 with EN and SYNC=1, the block SHALL clear the miss counter.
REQ-021 In LOCK at SL=0 with EN and SYNC=0, the block SHALL still capture the bit (flywheel) and increment the miss counter.
REQ-022 When the miss counter reaches MISS_LIMIT, on that edge the block SHALL pulse ERR, return to HUNT, set SL to 0, clear the miss counter and leave Q unchanged.
REQ-023 In LOCK at SL≠0 with EN and SYNC=1, the block SHALL pulse ERR, discard the partial frame (no VLD), store b in shadow[0], set SL to 1, clear the miss counter and stay in LOCK.
REQ-024 Simultaneous slot-3 completion and misaligned SYNC SHALL follow REQ-023: SYNC wins, with no VLD and no Q update.
REQ-025 Simultaneous slot-0 miss reaching MISS_LIMIT and frame start SHALL follow REQ-022.
REQ-026 The miss counter SHALL be 2 bits and SHALL saturate at MISS_LIMIT.

Reset
REQ-027 While RN=0, the block SHALL hold state HUNT, SL=0, Q=4'b0000, shadow=0, miss counter=0, VLD=0, ERR=0 and LOCKED=0, independent of CK.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after RN rises, operation SHALL resume at the first CK edge in HUNT.

Structure
REQ-029 Package hd_tdm_pkg SHALL hold the state enum (HUNT, LOCK), the slot typedef (2 bits) and the constant SLOTS=4.
REQ-030 The slot counter with wrap and load-to-1 SHALL be one sub-module, hd_tdm_slot_ctr; the FSM, shadow register and output registers SHALL stay in the top module.

Verification
REQ-031 The bench SHALL cover the following scenario. Stimulus: INVERT=1, EN=1, SYNC at slot 0, DIN=1,0,1,0. Required response: Q=4'b1010, VLD high exactly 1 cycle at the slot-3 edge, LOCKED=1.
REQ-032 The bench SHALL cover the following scenario. Stimulus: same frame with EN=0 for 3 cycles between slots 1 and 2. Required response: SL holds at 2, Q=4'b1010, VLD is still a single pulse.
REQ-033 The bench SHALL cover the following scenario. Stimulus: lock, then SYNC asserted at slot 2. Required response: ERR 1-cycle pulse, SL=1 next cycle, no VLD for that frame, Q unchanged.
REQ-034 The bench SHALL cover the following scenario. Stimulus: MISS_LIMIT=2, two consecutive frames with SYNC low at slot 0. Required response: first miss gives VLD as normal; the second miss gives an ERR pulse, LOCKED=0, SL=0 and Q holding the last frame.
REQ-035 The bench SHALL cover the following scenario. Stimulus: RN pulsed low at slot 2 of a frame. Required response: all outputs at reset values immediately without a CK edge; the next SYNC relocks and the following frame is correct.
REQ-036 The bench SHALL cover the following scenario. Stimulus: INVERT=0, DIN=1,1,0,0. Required response: Q=4'b0011.

Source files
------------

// File: rtl/hd_tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package hd_tdm_pkg;

  localparam int unsigned SLOTS  = 4;
  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned MISS_W = 2;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [MISS_W-1:0] miss_t;

endpackage

// File: rtl/hd_tdm_slot_ctr.sv
// Slot index counter: clear to 0, load to 1 on frame restart, or advance with wrap.
module hd_tdm_slot_ctr
  import hd_tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  load1,
  input  logic  adv,
  output slot_t slot
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= slot_t'(1);
    end else if (adv) begin
      slot <= slot + slot_t'(1);
    end
  end

endmodule

// File: rtl/hd_tdm_demux4.sv
// Recovers 4-bit frames from a serial inverting-mux stream, with SYNC-based
// frame lock, flywheel over missing marks and realignment on misplaced marks.
module hd_tdm_demux4
  import hd_tdm_pkg::*;
#(
  parameter bit          INVERT     = 1'b1,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             DIN,
  input  logic             SYNC,
  input  logic             EN,
  output logic [1:0]       SL,
  output logic [SLOTS-1:0] Q,
  output logic             VLD,
  output logic             ERR,
  output logic             LOCKED
);

  localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);

  state_t           state, state_nxt;
  logic [SLOTS-2:0] shadow, shadow_nxt;
  miss_t            miss, miss_nxt, miss_inc;
  logic [SLOTS-1:0] q_r, q_nxt;
  logic             vld_r, vld_nxt;
  logic             err_r, err_nxt;
  logic             locked_r;
  logic             ctr_clr, ctr_load1, ctr_adv;
  slot_t            slot;
  logic             b;

  assign b = DIN ^ INVERT;

  hd_tdm_slot_ctr u_slot_ctr (
    .clk   (CK),
    .rst_n (RN),
    .clr   (ctr_clr),
    .load1 (ctr_load1),
    .adv   (ctr_adv),
    .slot  (slot)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state    <= HUNT;
      shadow   <= '0;
      miss     <= '0;
      q_r      <= '0;
      vld_r    <= 1'b0;
      err_r    <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      shadow   <= shadow_nxt;
      miss     <= miss_nxt;
      q_r      <= q_nxt;
      vld_r    <= vld_nxt;
      err_r    <= err_nxt;
      locked_r <= (state_nxt == LOCK);
    end
  end

  // Next-state, capture and pulse generation; every decision is gated by EN.
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    miss_nxt   = miss;
    q_nxt      = q_r;
    vld_nxt    = 1'b0;
    err_nxt    = 1'b0;
    ctr_clr    = 1'b0;
    ctr_load1  = 1'b0;
    ctr_adv    = 1'b0;
    miss_inc   = (miss == miss_t'(MISS_LIMIT)) ? miss : miss + miss_t'(1);

    if (EN) begin
      case (state)
        HUNT: begin
          if (SYNC) begin
            shadow_nxt[0] = b;
            ctr_load1     = 1'b1;
            miss_nxt      = '0;
            state_nxt     = LOCK;
          end
        end
        LOCK: begin
          if (SYNC && (slot != '0)) begin
            // Misplaced mark wins over any frame completion: restart at slot 1.
            err_nxt       = 1'b1;
            shadow_nxt[0] = b;
            ctr_load1     = 1'b1;
            miss_nxt      = '0;
          end else if (slot == '0) begin
            if (SYNC) begin
              miss_nxt      = '0;
              shadow_nxt[0] = b;
              ctr_adv       = 1'b1;
            end else if (miss_inc == miss_t'(MISS_LIMIT)) begin
              err_nxt   = 1'b1;
              state_nxt = HUNT;
              ctr_clr   = 1'b1;
              miss_nxt  = '0;
            end else begin
              miss_nxt      = miss_inc;
              shadow_nxt[0] = b;
              ctr_adv       = 1'b1;
            end
          end else if (slot == LAST_SLOT) begin
            q_nxt   = {b, shadow};
            vld_nxt = 1'b1;
            ctr_adv = 1'b1;
          end else begin
            shadow_nxt[slot] = b;
            ctr_adv          = 1'b1;
          end
        end
      endcase
    end
  end

  assign SL     = slot;
  assign Q      = q_r;
  assign VLD    = vld_r;
  assign ERR    = err_r;
  assign LOCKED = locked_r;

endmodule
